// File: rtl/ble_ahb_reg_master_if.sv
// Bundle of signals between the register-map initiator and its neighbours:
// the valid/ready command port, the response pulse, and the AHB-Lite bus.
// The master modport is the initiator's view; slave is the far side of it
// (command source, response sink and bus slave together).
interface ble_ahb_reg_master_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 8
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  logic                rsp_valid;
  logic                rsp_write;
  logic [ADDR_W-1:0]   rsp_addr;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [ERRCNT_W-1:0] err_count;

  logic                hsel;
  logic [ADDR_W-1:0]   haddr;
  logic [1:0]          htrans;
  logic                hwrite;
  logic [2:0]          hsize;
  logic [2:0]          hburst;
  logic [DATA_W-1:0]   hwdata;
  logic [DATA_W-1:0]   hrdata;
  logic                hready;
  logic                hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err, err_count,
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err, err_count,
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ble_ahb_reg_master.sv
// AHB-Lite single-transfer initiator for the BLE register map.
// Two-stage pipeline: stage A owns the address phase, stage D the data phase.
// One response per accepted command, in issue order.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | normal operation, A may present NONSEQ
//   ST_ERR2 | second cycle of an ERROR response; address phase cancelled,
//           | A is kept and re-presented once the ERROR completes
module ble_ahb_reg_master #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input logic                  hclk,
  input logic                  hresetn,
  ble_ahb_reg_master_if.master bus
);

  localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_ERR2 = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_a_valid;
  logic                r_a_write;
  logic [ADDR_W-1:0]   r_a_addr;
  logic [DATA_W-1:0]   r_a_wdata;

  logic                r_d_valid;
  logic                r_d_write;
  logic [ADDR_W-1:0]   r_d_addr;
  logic [DATA_W-1:0]   r_d_wdata;

  logic                r_rsp_valid;
  logic                r_rsp_write;
  logic                r_rsp_err;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [ERRCNT_W-1:0] r_err_count;

  logic w_err_hold;
  logic w_nonseq;
  logic w_cmd_ready;
  logic w_accept;
  logic w_a_to_d;
  logic w_d_done;

  // Error-hold state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // Next state and pipeline advance decode
  always_comb begin
    w_state_nxt = r_state;
    w_err_hold  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!bus.hready && bus.hresp) w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        w_err_hold = 1'b1;
        if (bus.hready) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
    w_nonseq    = r_a_valid & ~w_err_hold;
    // hready feeds cmd_ready combinationally so a full pipeline still
    // accepts one command per cycle when the slave has no wait states.
    w_cmd_ready = ~r_a_valid | (bus.hready & ~bus.hresp & ~w_err_hold);
    w_accept    = bus.cmd_valid & w_cmd_ready;
    w_a_to_d    = bus.hready & w_nonseq;
    w_d_done    = bus.hready & r_d_valid;
  end

  // Address stage: load on handshake, empty when its address phase is taken.
  // Address/direction are not cleared so haddr/hwrite hold while IDLE.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_a_valid <= 1'b0;
      r_a_write <= 1'b0;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_write <= bus.cmd_write;
      r_a_addr  <= bus.cmd_addr & ADDR_WORD_MASK;
      r_a_wdata <= bus.cmd_wdata;
    end else if (w_a_to_d) begin
      r_a_valid <= 1'b0;
    end
  end

  // Data stage: advances only when the bus is ready, frozen through waits
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_d_valid <= 1'b0;
      r_d_write <= 1'b0;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
    end else if (bus.hready) begin
      r_d_valid <= w_a_to_d;
      if (w_a_to_d) begin
        r_d_write <= r_a_write;
        r_d_addr  <= r_a_addr;
        r_d_wdata <= r_a_wdata;
      end
    end
  end

  // Response pulse for the transfer completing in the data stage
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_d_done;
      if (w_d_done) begin
        r_rsp_write <= r_d_write;
        r_rsp_err   <= bus.hresp;
        r_rsp_addr  <= r_d_addr;
        r_rsp_rdata <= (r_d_write | bus.hresp) ? '0 : bus.hrdata;
      end
    end
  end

  // Saturating count of transfers that ended with ERROR
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_err_count <= '0;
    end else if (w_d_done && bus.hresp && (r_err_count != {ERRCNT_W{1'b1}})) begin
      r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.htrans    = w_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.hsel      = w_nonseq;
  assign bus.haddr     = r_a_addr;
  assign bus.hwrite    = r_a_write;
  assign bus.hsize     = 3'b010;
  assign bus.hburst    = 3'b000;
  assign bus.hwdata    = r_d_wdata;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_addr  = r_rsp_addr;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_ble_ahb_reg_master.sv
// Bench for ble_ahb_reg_master. A scripted AHB slave plus a transaction-level
// model (commands in order -> one address phase each -> one data phase each ->
// one response each) is checked against the DUT every cycle, and each directed
// scenario ends with hand-computed literal expectations.
module tb_ble_ahb_reg_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 8;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] WMASK = 32'hFFFF_FFFC;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          acc;
  } cmd_t;

  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } scr_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          cyc;
  } rsp_t;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  ble_ahb_reg_master_if #(.ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) bus ();

  ble_ahb_reg_master #(.ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  cmd_t cmd_q[$];
  scr_t scr_q[$];
  cmd_t issue_q[$];
  rsp_t exp_q[$];
  rsp_t rsp_log[$];
  int   aph_log[$];

  bit          dp_active = 1'b0;
  logic        dp_w = 1'b0;
  logic [31:0] dp_a = '0;
  logic [31:0] dp_d = '0;
  logic [31:0] dp_rdata = '0;
  logic        dp_err = 1'b0;
  int          dp_waits = 0;
  bit          dp_eph = 1'b0;
  int          dp_acc = 0;

  logic [7:0]  errcnt_m = '0;
  logic [31:0] last_haddr = '0;
  logic        last_hwrite = 1'b0;
  int          rdy_low = 0;
  int          ecyc2_cnt = 0;

  bit          ecyc2;
  logic        exp_rdy;
  logic [1:0]  exp_trans;
  logic        hs;
  rsp_t        r_exp;
  rsp_t        r_new;
  cmd_t        c_it;
  scr_t        s_it;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic err, input logic [31:0] rdata);
    cmd_t c;
    scr_t s;
    c.w = w; c.a = a; c.d = d; c.acc = 0;
    s.waits = waits; s.err = err; s.rdata = rdata;
    cmd_q.push_back(c);
    scr_q.push_back(s);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while ((cmd_q.size() > 0 || issue_q.size() > 0 || dp_active || exp_q.size() > 0) && n < max) begin
      @(negedge hclk);
      #2;
      n++;
    end
    chk({tag, "_idle"}, 64'(n < max), 64'(1));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_htrans"},    64'(bus.htrans),    64'(0));
    chk({tag, "_hsel"},      64'(bus.hsel),      64'(0));
    chk({tag, "_haddr"},     64'(bus.haddr),     64'(0));
    chk({tag, "_hwrite"},    64'(bus.hwrite),    64'(0));
    chk({tag, "_hwdata"},    64'(bus.hwdata),    64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
    chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'(0));
    chk({tag, "_rsp_write"}, 64'(bus.rsp_write), 64'(0));
    chk({tag, "_rsp_addr"},  64'(bus.rsp_addr),  64'(0));
    chk({tag, "_err_count"}, 64'(bus.err_count), 64'(0));
  endtask

  // Slave, command driver and per-cycle compare against the transaction model
  always @(negedge hclk) begin
    cyc = cyc + 1;
    if (!hresetn) begin
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
      cmd_q.delete(); scr_q.delete(); issue_q.delete(); exp_q.delete();
      dp_active = 1'b0; errcnt_m = '0; last_haddr = '0; last_hwrite = 1'b0;
    end else begin
      ecyc2 = dp_active && dp_err && dp_eph;
      if (!dp_active) begin
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = JUNK;
      end else if (dp_waits > 0) begin
        bus.hready = 1'b0; bus.hresp = 1'b0; bus.hrdata = JUNK;
      end else if (dp_err && !dp_eph) begin
        bus.hready = 1'b0; bus.hresp = 1'b1; bus.hrdata = JUNK;
      end else if (dp_err) begin
        bus.hready = 1'b1; bus.hresp = 1'b1; bus.hrdata = JUNK;
      end else begin
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = dp_w ? JUNK : dp_rdata;
      end
      if (cmd_q.size() > 0) begin
        bus.cmd_valid = 1'b1; bus.cmd_write = cmd_q[0].w;
        bus.cmd_addr = cmd_q[0].a; bus.cmd_wdata = cmd_q[0].d;
      end else begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      end
      #1;
      exp_trans = (issue_q.size() > 0 && !ecyc2) ? 2'b10 : 2'b00;
      chk("htrans", 64'(bus.htrans), 64'(exp_trans));
      chk("hsel",   64'(bus.hsel),   64'(exp_trans[1]));
      chk("hsize",  64'(bus.hsize),  64'(3'b010));
      chk("hburst", 64'(bus.hburst), 64'(3'b000));
      if (issue_q.size() > 0) begin
        chk("haddr",  64'(bus.haddr),  64'(issue_q[0].a & WMASK));
        chk("hwrite", 64'(bus.hwrite), 64'(issue_q[0].w));
      end else begin
        chk("haddr_hold",  64'(bus.haddr),  64'(last_haddr));
        chk("hwrite_hold", 64'(bus.hwrite), 64'(last_hwrite));
      end
      if (dp_active && dp_w) chk("hwdata", 64'(bus.hwdata), 64'(dp_d));
      exp_rdy = (issue_q.size() == 0) || (bus.hready && !bus.hresp && !ecyc2);
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(exp_rdy));
      if (!bus.cmd_ready) rdy_low++;
      if (ecyc2) ecyc2_cnt++;
      if (exp_q.size() > 0) begin
        r_exp = exp_q.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("rsp_write", 64'(bus.rsp_write), 64'(r_exp.w));
        chk("rsp_addr",  64'(bus.rsp_addr),  64'(r_exp.a));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(r_exp.rdata));
        chk("rsp_err",   64'(bus.rsp_err),   64'(r_exp.err));
        r_new = r_exp;
        r_new.w = bus.rsp_write; r_new.a = bus.rsp_addr;
        r_new.rdata = bus.rsp_rdata; r_new.err = bus.rsp_err;
        r_new.cyc = cyc;
        rsp_log.push_back(r_new);
      end else begin
        chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
      end
      chk("err_count", 64'(bus.err_count), 64'(errcnt_m));

      // What the coming rising edge does at transaction level
      hs = bus.cmd_valid && bus.cmd_ready;
      if (bus.hready) begin
        if (dp_active) begin
          r_exp.w = dp_w; r_exp.a = dp_a; r_exp.err = dp_err; r_exp.acc = dp_acc; r_exp.cyc = 0;
          r_exp.rdata = (dp_w || dp_err) ? 32'h0 : dp_rdata;
          exp_q.push_back(r_exp);
          if (dp_err && errcnt_m != 8'hFF) errcnt_m = errcnt_m + 8'd1;
        end
        if (issue_q.size() > 0 && !ecyc2) begin
          c_it = issue_q.pop_front();
          if (scr_q.size() > 0) s_it = scr_q.pop_front();
          else begin s_it.waits = 0; s_it.err = 1'b0; s_it.rdata = 32'h0; end
          dp_active = 1'b1; dp_w = c_it.w; dp_a = c_it.a & WMASK; dp_d = c_it.d; dp_acc = c_it.acc;
          dp_waits = s_it.waits; dp_err = s_it.err; dp_rdata = s_it.rdata; dp_eph = 1'b0;
          aph_log.push_back(cyc);
        end else begin
          dp_active = 1'b0;
        end
      end else if (dp_active) begin
        if (dp_waits > 0) dp_waits--;
        else if (dp_err) dp_eph = 1'b1;
      end
      if (hs && cmd_q.size() > 0) begin
        c_it = cmd_q.pop_front();
        c_it.acc = cyc + 1;
        issue_q.push_back(c_it);
        last_haddr = c_it.a & WMASK;
        last_hwrite = c_it.w;
      end
    end
  end

  initial begin
    int n;
    int nerr;
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    #1;
    reset_checks("rst0");
    @(negedge hclk);
    #2 hresetn = 1'b1;

    // Single write
    rsp_log.delete(); aph_log.delete();
    send(1'b1, 32'h0100_0100, 32'hA5A5_0001, 0, 1'b0, 32'h0);
    wait_idle(50, "t1");
    chk("t1_nrsp", 64'(rsp_log.size()), 64'(1));
    if (rsp_log.size() >= 1) begin
      chk("t1_addr",  64'(rsp_log[0].a),     64'(32'h0100_0100));
      chk("t1_err",   64'(rsp_log[0].err),   64'(0));
      chk("t1_rdata", 64'(rsp_log[0].rdata), 64'(0));
      chk("t1_lat",   64'(rsp_log[0].cyc - rsp_log[0].acc), 64'(2));
    end

    // Back-to-back reads
    rsp_log.delete(); aph_log.delete();
    send(1'b0, 32'h0100_0104, 32'h0, 0, 1'b0, 32'h11);
    send(1'b0, 32'h0100_0108, 32'h0, 0, 1'b0, 32'h22);
    wait_idle(50, "t2");
    chk("t2_nrsp", 64'(rsp_log.size()), 64'(2));
    if (rsp_log.size() >= 2 && aph_log.size() >= 2) begin
      chk("t2_rdata0", 64'(rsp_log[0].rdata), 64'(32'h11));
      chk("t2_rdata1", 64'(rsp_log[1].rdata), 64'(32'h22));
      chk("t2_rsp_gap", 64'(rsp_log[1].cyc - rsp_log[0].cyc), 64'(1));
      chk("t2_aph_gap", 64'(aph_log[1] - aph_log[0]), 64'(1));
    end

    // Wait states in the write data phase with a read queued behind it
    rsp_log.delete(); rdy_low = 0;
    send(1'b1, 32'h0100_0110, 32'hCAFE_0003, 3, 1'b0, 32'h0);
    send(1'b0, 32'h0100_0114, 32'h0, 0, 1'b0, 32'h33);
    wait_idle(50, "t3");
    chk("t3_nrsp", 64'(rsp_log.size()), 64'(2));
    chk("t3_rdy_low", 64'(rdy_low), 64'(3));
    if (rsp_log.size() >= 2) begin
      chk("t3_w_addr", 64'(rsp_log[0].a),     64'(32'h0100_0110));
      chk("t3_rdata",  64'(rsp_log[1].rdata), 64'(32'h33));
      chk("t3_gap",    64'(rsp_log[1].cyc - rsp_log[0].cyc), 64'(1));
    end

    // ERROR on a write with a read waiting in the address stage
    rsp_log.delete(); ecyc2_cnt = 0;
    send(1'b1, 32'h0100_0200, 32'hBEEF_0004, 0, 1'b1, 32'h0);
    send(1'b0, 32'h0100_0204, 32'h0, 0, 1'b0, 32'h44);
    wait_idle(50, "t4");
    chk("t4_nrsp", 64'(rsp_log.size()), 64'(2));
    chk("t4_ecyc2", 64'(ecyc2_cnt), 64'(1));
    chk("t4_err_count", 64'(bus.err_count), 64'(8'h01));
    if (rsp_log.size() >= 2) begin
      chk("t4_w_err",   64'(rsp_log[0].err),   64'(1));
      chk("t4_w_rdata", 64'(rsp_log[0].rdata), 64'(0));
      chk("t4_r_err",   64'(rsp_log[1].err),   64'(0));
      chk("t4_r_addr",  64'(rsp_log[1].a),     64'(32'h0100_0204));
      chk("t4_r_rdata", 64'(rsp_log[1].rdata), 64'(32'h44));
    end

    // Error counter saturation
    rsp_log.delete();
    for (int i = 0; i < 256; i++)
      send(1'b1, 32'h0100_0000 + 32'((i % 78) * 4), 32'(i), 0, 1'b1, 32'h0);
    wait_idle(4000, "t5");
    nerr = 0;
    foreach (rsp_log[k]) if (rsp_log[k].err) nerr++;
    chk("t5_nerr", 64'(nerr), 64'(256));
    chk("t5_err_count", 64'(bus.err_count), 64'(8'hFF));

    // Reset during a wait-stated read
    rsp_log.delete();
    send(1'b0, 32'h0100_0120, 32'h0, 20, 1'b0, 32'h55);
    n = 0;
    while (!(dp_active && !dp_w) && n < 20) begin
      @(negedge hclk);
      #2;
      n++;
    end
    chk("t6_reach_wait", 64'(n < 20), 64'(1));
    repeat (2) @(negedge hclk);
    #3 hresetn = 1'b0;
    #1;
    reset_checks("t6");
    @(negedge hclk);
    #2 hresetn = 1'b1;
    chk("t6_no_rsp", 64'(rsp_log.size()), 64'(0));
    send(1'b1, 32'h0100_0124, 32'h1234_5678, 0, 1'b0, 32'h0);
    wait_idle(50, "t6b");
    chk("t6_nrsp", 64'(rsp_log.size()), 64'(1));
    if (rsp_log.size() >= 1) begin
      chk("t6_addr", 64'(rsp_log[0].a),   64'(32'h0100_0124));
      chk("t6_err",  64'(rsp_log[0].err), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ble_ahb_reg_master.md
Name: ble_ahb_reg_master

Overview:
- AHB-Lite single-transfer initiator that drives the BLE register-map bus (status register, ADV register block 32'h0100_0000–32'h0100_0134) from a simple valid/ready command port.
- Used by the BLE controller and by bench sequencers to issue register reads and writes.
- Two-stage pipeline (address stage A, data stage D) with overlapped address/data phases.
- Handles wait states and the two-cycle ERROR response, and returns one response per command in issue order.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (word transfers only).
- ERRCNT_W, 8, width of saturating error counter.

Ports:
- hclk  in  1  bus clock; all state on rising edge.
- hresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; bits [1:0] ignored, driven as 0.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_write  out  1  type of completed transfer.
- rsp_addr  out  ADDR_W  address of completed transfer.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  transfer ended with ERROR.
- err_count  out  ERRCNT_W  saturating count of ERROR responses.
- hsel  out  1  = htrans[1].
- haddr  out  ADDR_W  address phase address.
- htrans  out  2  2'b00 IDLE / 2'b10 NONSEQ only.
- hwrite  out  1  address phase direction.
- hsize  out  3  constant 3'b010.
- hburst  out  3  constant 3'b000 (SINGLE).
- hwdata  out  DATA_W  data phase write data.
- hrdata  in  DATA_W  slave read data.
- hready  in  1  transfer done / bus free.
- hresp  in  1  0 OKAY, 1 ERROR.

Behaviour:

Reset (async, hresetn=0):
- A and D invalid; err_hold=0.
- htrans=IDLE, hsel=0, haddr=0, hwrite=0, hwdata=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_write=0, rsp_addr=0, err_count=0.
- Reset mid-transfer drops all in-flight commands with no response. Bus is IDLE from the first cycle after release.

Address stage A:
- Holds {valid, addr, write, wdata}.
- When A.valid & !err_hold, drives htrans=NONSEQ, haddr=A.addr, hwrite=A.write. Otherwise htrans=IDLE and haddr/hwrite hold their last value.
- cmd_ready = !A.valid | (hready & !hresp & !err_hold). This combinational path from hready is intentional.

Data stage D:
- Holds {valid, addr, write, wdata}.
- hwdata = D.wdata for the whole data phase, stable through wait states.

Advance rule, on each edge with hready=1:
- D.valid and the bus is not in error cycle 2: D completes. rsp_valid=1 next cycle, rsp_rdata = D.write ? 0 : hrdata, rsp_err=0.
- A.valid and htrans was NONSEQ: A moves to D. Otherwise D.valid is cleared.
- Command handshake: A loads the new command; else A.valid is cleared if it moved to D.

Wait states (hready=0, hresp=0):
- A, D and all bus outputs are frozen; cmd_ready=0 if A.valid.

ERROR handling:
- Cycle 1 (hready=0, hresp=1): at that edge set err_hold=1.
- Cycle 2: htrans is forced IDLE and A is retained (transfer cancelled, not lost).
- Edge with hready=1, hresp=1: D completes with rsp_err=1 and rsp_rdata=0. err_count increments, saturating at all-ones. err_hold is cleared. A is re-presented as NONSEQ in the following cycle.
- ERROR with A empty: only D completes with error.

Ordering and throughput:
- Responses are returned strictly in command order; exactly one response per accepted command.
- Back-to-back commands with zero wait states: one transfer per cycle.
- First response appears 2 cycles after acceptance.
- rsp_valid is never back-pressured; the consumer must accept every pulse.

Test Plan:
- Single write: cmd write 32'h0100_0100 / 32'hA5A5_0001, hready=1 → NONSEQ next cycle, hwdata=32'hA5A5_0001 the cycle after, rsp_valid with rsp_err=0 two cycles after acceptance.
- Back-to-back reads of 32'h0100_0104 and 32'h0100_0108 with slave returning 32'h11 and 32'h22, no waits → consecutive NONSEQ cycles, responses in order with rdata 32'h11 then 32'h22, one cycle apart.
- Wait states: write followed by read, slave holds hready=0 for 3 cycles in the write data phase → haddr and hwdata frozen, cmd_ready=0, read address phase completes only after hready=1, both responses correct.
- Error with pipelined next: write 32'h0100_0200 gets ERROR while a read is in A → htrans IDLE in error cycle 2, rsp_err=1 for the write, err_count=1, read re-issued and completes OK.
- Saturation: 256 consecutive ERROR writes with ERRCNT_W=8 → err_count stops at 8'hFF.
- Reset mid-operation: assert hresetn=0 during a wait-stated read → outputs go to reset values immediately, no rsp_valid, the new command after release completes normally.
